// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding and default sizing.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_LATENCY = 2;
  localparam int LAT_CNT_W   = 4;

endpackage

// File: rtl/dmem_array.sv
// Single-port 32-bit word storage: synchronous write, registered read.
// The read register can be cleared so store/error responses carry zero data.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] rdata_d, rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (clr)     rdata_d = '0;
    else if (re) rdata_d = mem[addr];
  end

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (we) mem[addr] <= wdata;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Request/response data-memory target with a fixed access latency.
// Optional macro DMEM_ERR_EN flags misaligned or out-of-range addresses via resp_err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  state_e               state_q, state_d;
  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    idx_q, idx_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 err_q, err_d;
  logic                 resp_err_q, resp_err_d;
  logic                 access, req_err;
  logic                 arr_we, arr_re, arr_clr;

`ifdef DMEM_ERR_EN
  assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W+2] != '0);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[1:0], req_addr[31:ADDR_W+2]};
  assign req_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      resp_err_q <= resp_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    resp_err_d = resp_err_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    access     = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          idx_d   = req_addr[ADDR_W+1:2];
          wdata_d = req_wdata;
          err_d   = req_err;
          cnt_d   = LAT_CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          access     = 1'b1;
          resp_err_d = err_q;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A reset landing on the access edge must not commit the pending store.
  assign arr_we  = access && we_q && !err_q && rst;
  assign arr_re  = access && !we_q && !err_q;
  assign arr_clr = !rst || (access && (we_q || err_q));

  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .clr   (arr_clr),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (resp_rdata)
  );

  assign resp_err = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 2 and 1), table vectors,
// hand-written reset corner cases and randomized traffic against a word-array model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid, req_we, resp_ready;
  logic [31:0] req_addr, req_wdata;

  logic        rv0, rv1, rr0, rr1;
  logic        req_ready0, req_ready1, resp_valid0, resp_valid1, resp_err0, resp_err1;
  logic [31:0] resp_rdata0, resp_rdata1;
  logic        m_req_ready, m_resp_valid, m_resp_err;
  logic [31:0] m_resp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rv0 = req_valid & ~sel;
  assign rv1 = req_valid & sel;
  assign rr0 = resp_ready & ~sel;
  assign rr1 = resp_ready & sel;
  assign m_req_ready  = sel ? req_ready1  : req_ready0;
  assign m_resp_valid = sel ? resp_valid1 : resp_valid0;
  assign m_resp_err   = sel ? resp_err1   : resp_err0;
  assign m_resp_rdata = sel ? resp_rdata1 : resp_rdata0;

  dmem_responder #(.ADDR_W(8), .LATENCY(2)) dut0 (
    .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(req_ready0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid0),
    .resp_ready(rr0), .resp_rdata(resp_rdata0), .resp_err(resp_err0));

  dmem_responder #(.ADDR_W(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(req_ready1), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid1),
    .resp_ready(rr1), .resp_rdata(resp_rdata1), .resp_err(resp_err1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One full transaction on the selected instance; hold = cycles resp_ready stays low.
  task automatic txn(input logic s, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] rd, output logic er);
    int lat;
    int k;
    logic [31:0] rd0;
    logic er0;
    @(negedge clk);
    sel = s;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; resp_ready = 1'b0;
    #1;
    k = 0;
    while (!m_req_ready && k < 50) begin @(negedge clk); k++; end
    chk("req_ready_wait", {31'd0, (k < 50)}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (m_resp_valid) begin lat = n - 1; break; end
      chk("req_ready_busy", {31'd0, m_req_ready}, 32'd0);
    end
    chk("latency", lat, s ? 32'd1 : 32'd2);
    rd0 = m_resp_rdata;
    er0 = m_resp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      req_valid = (h == 1); req_we = 1'b1; req_wdata = $urandom; req_addr = addr;
      @(negedge clk);
      chk("hold_valid", {31'd0, m_resp_valid}, 32'd1);
      chk("hold_rdata", m_resp_rdata, rd0);
      chk("hold_err", {31'd0, m_resp_err}, {31'd0, er0});
      chk("hold_req_ready", {31'd0, m_req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("post_valid", {31'd0, m_resp_valid}, 32'd0);
    chk("post_req_ready", {31'd0, m_req_ready}, 32'd1);
    resp_ready = 1'b0;
    rd = rd0;
    er = er0;
  endtask

  typedef struct {
    logic        s;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];
  logic [31:0] mem_m [2][256];
  bit          known [2][256];

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] a, wd;
    logic        s, we, e;
    int          idx, hold;

    vecs[0] = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 0, 32'h0,        1'b0};
    vecs[1] = '{1'b0, 1'b0, 32'h10,  32'h0,        0, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 32'h10,  32'h0,        5, 32'hDEADBEEF, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'h3FC, 32'hCAFEF00D, 0, 32'h0,        1'b0};
    vecs[4] = '{1'b1, 1'b0, 32'h3FC, 32'h0,        2, 32'hCAFEF00D, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 32'h0,   32'h11111111, 0, 32'h0,        1'b0};
`ifdef DMEM_ERR_EN
    vecs[6] = '{1'b0, 1'b1, 32'h402, 32'h22222222, 0, 32'h0,        1'b1};
    vecs[7] = '{1'b0, 1'b0, 32'h0,   32'h0,        0, 32'h11111111, 1'b0};
`else
    vecs[6] = '{1'b0, 1'b1, 32'h402, 32'h22222222, 0, 32'h0,        1'b0};
    vecs[7] = '{1'b0, 1'b0, 32'h0,   32'h0,        0, 32'h22222222, 1'b0};
`endif

    rst = 1'b0; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_req_ready0", {31'd0, req_ready0}, 32'd1);
    chk("rst_resp_valid0", {31'd0, resp_valid0}, 32'd0);
    chk("rst_rdata0", resp_rdata0, 32'd0);
    chk("rst_err0", {31'd0, resp_err0}, 32'd0);
    chk("rst_req_ready1", {31'd0, req_ready1}, 32'd1);
    chk("rst_resp_valid1", {31'd0, resp_valid1}, 32'd0);
    chk("rst_rdata1", resp_rdata1, 32'd0);

    for (int i = 0; i < 8; i++) begin
      txn(vecs[i].s, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].hold, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
    end

    // Reset during WAIT discards the pending store.
    txn(1'b0, 1'b1, 32'h20, 32'hAAAA5555, 0, rd, er);
    @(negedge clk);
    sel = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("wait_rst_req_ready", {31'd0, req_ready0}, 32'd1);
    chk("wait_rst_resp_valid", {31'd0, resp_valid0}, 32'd0);
    txn(1'b0, 1'b0, 32'h20, 32'h0, 0, rd, er);
    chk("wait_rst_old_data", rd, 32'hAAAA5555);

    // Reset during RESP drops the response.
    @(negedge clk);
    sel = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("resp_pending_valid", {31'd0, resp_valid0}, 32'd1);
    chk("resp_pending_rdata", resp_rdata0, 32'hAAAA5555);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("resp_rst_valid", {31'd0, resp_valid0}, 32'd0);
    chk("resp_rst_rdata", resp_rdata0, 32'd0);
    chk("resp_rst_req_ready", {31'd0, req_ready0}, 32'd1);

    // Randomized traffic against a word-array model.
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 256; w++) known[d][w] = 1'b0;
    for (int t = 0; t < 60; t++) begin
      s  = $urandom_range(1, 0);
      we = $urandom_range(1, 0);
      wd = $urandom;
      hold = $urandom_range(3, 0);
      if ($urandom_range(3, 0) != 0) a = {24'd0, 4'd0, 4'($urandom_range(15, 0))} << 2;
      else a = $urandom;
`ifdef DMEM_ERR_EN
      e = (a % 4 != 0) || (a >= 32'd1024);
`else
      e = 1'b0;
`endif
      idx = int'((a / 4) % 256);
      txn(s, we, a, wd, hold, rd, er);
      chk("rnd_err", {31'd0, er}, {31'd0, e});
      if (we) begin
        chk("rnd_store_rdata", rd, 32'd0);
        if (!e) begin mem_m[s][idx] = wd; known[s][idx] = 1'b1; end
      end else if (e) begin
        chk("rnd_err_load_rdata", rd, 32'd0);
      end else if (known[s][idx]) begin
        chk("rnd_load_rdata", rd, mem_m[s][idx]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
